// File: rtl/thinkgear_pkg.sv
// Shared constants, state encoding and output field layout for the ThinkGear packet parser.
package thinkgear_pkg;

  localparam logic [7:0] SYNC              = 8'hAA;
  localparam logic [7:0] EXCODE            = 8'h55;
  localparam logic [7:0] CODE_SIGNAL       = 8'h02;
  localparam logic [7:0] CODE_ATTN         = 8'h04;
  localparam logic [7:0] CODE_MED          = 8'h05;
  localparam logic [7:0] CODE_BLINK        = 8'h16;
  localparam logic [7:0] MULTI_BYTE_THRESH = 8'h80;

  localparam int SIG_LSB  = 16;
  localparam int ATTN_LSB = 8;
  localparam int MED_LSB  = 0;

  localparam logic [23:0] OUT_RESET = 24'hC8_00_00;

  typedef enum logic [2:0] {
    ST_SYNC1 = 3'd0,
    ST_SYNC2 = 3'd1,
    ST_PLEN  = 3'd2,
    ST_CODE  = 3'd3,
    ST_VLEN  = 3'd4,
    ST_VALUE = 3'd5,
    ST_CHK   = 3'd6
  } tg_state_e;

  // The checksum byte is the ones' complement of the low byte of the payload sum.
  function automatic logic csum_ok(input logic [7:0] sum, input logic [7:0] chk);
    return (chk == ~sum);
  endfunction

endpackage

// File: rtl/thinkgear_parser.sv
// ThinkGear byte-stream parser: validates framing and checksum, then commits
// poor-signal / attention / meditation / blink values from good packets only.
module thinkgear_parser
  import thinkgear_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 5_000_000,
  parameter int MAX_PLEN       = 169
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [23:0] out_data,
  output logic [7:0]  blink_strength,
  output logic        blink,
  output logic        pkt_ok,
  output logic        chk_err
);

  localparam logic [31:0] TO_LAST  = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]  PLEN_MAX = 8'(MAX_PLEN);

  tg_state_e   r_state;
  logic [7:0]  r_sum;
  logic [7:0]  r_remain;
  logic [7:0]  r_vcnt;
  logic [7:0]  r_code;
  logic        r_malformed;
  logic [31:0] r_idle;

  logic [7:0]  r_sh_sig, r_sh_attn, r_sh_med, r_sh_blink;
  logic        r_has_sig, r_has_attn, r_has_med, r_has_blink;

  logic [23:0] r_out_data;
  logic [7:0]  r_blink_strength;
  logic        r_blink, r_pkt_ok, r_chk_err;

  logic [7:0]  w_sum_nxt;
  logic [7:0]  w_remain_nxt;
  logic        w_good;

  assign w_sum_nxt    = r_sum + rx_data;
  assign w_remain_nxt = r_remain - 8'd1;
  assign w_good       = csum_ok(r_sum, rx_data) && !r_malformed;

  assign out_data       = r_out_data;
  assign blink_strength = r_blink_strength;
  assign blink          = r_blink;
  assign pkt_ok         = r_pkt_ok;
  assign chk_err        = r_chk_err;

  // Packet FSM, shadow capture, commit and inter-byte timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state          <= ST_SYNC1;
      r_sum            <= 8'd0;
      r_remain         <= 8'd0;
      r_vcnt           <= 8'd0;
      r_code           <= 8'd0;
      r_malformed      <= 1'b0;
      r_idle           <= 32'd0;
      r_sh_sig         <= 8'd0;
      r_sh_attn        <= 8'd0;
      r_sh_med         <= 8'd0;
      r_sh_blink       <= 8'd0;
      r_has_sig        <= 1'b0;
      r_has_attn       <= 1'b0;
      r_has_med        <= 1'b0;
      r_has_blink      <= 1'b0;
      r_out_data       <= OUT_RESET;
      r_blink_strength <= 8'd0;
      r_blink          <= 1'b0;
      r_pkt_ok         <= 1'b0;
      r_chk_err        <= 1'b0;
    end else begin
      r_blink   <= 1'b0;
      r_pkt_ok  <= 1'b0;
      r_chk_err <= 1'b0;
      if (rx_valid) begin
        r_idle <= 32'd0;
        case (r_state)
          ST_SYNC1: begin
            if (rx_data == SYNC) r_state <= ST_SYNC2;
            else                 r_state <= ST_SYNC1;
          end
          ST_SYNC2: begin
            if (rx_data == SYNC) r_state <= ST_PLEN;
            else                 r_state <= ST_SYNC1;
          end
          ST_PLEN: begin
            if (rx_data == SYNC) begin
              r_state <= ST_PLEN;
            end else if (rx_data > PLEN_MAX) begin
              r_state <= ST_SYNC1;
            end else begin
              r_remain    <= rx_data;
              r_sum       <= 8'd0;
              r_malformed <= 1'b0;
              r_has_sig   <= 1'b0;
              r_has_attn  <= 1'b0;
              r_has_med   <= 1'b0;
              r_has_blink <= 1'b0;
              if (rx_data == 8'd0) r_state <= ST_CHK;
              else                 r_state <= ST_CODE;
            end
          end
          ST_CODE: begin
            r_sum    <= w_sum_nxt;
            r_remain <= w_remain_nxt;
            r_code   <= rx_data;
            if (rx_data == EXCODE) begin
              r_state <= (w_remain_nxt == 8'd0) ? ST_CHK : ST_CODE;
            end else if (w_remain_nxt == 8'd0) begin
              // A code with no room left for its value can never be complete.
              r_malformed <= 1'b1;
              r_state     <= ST_CHK;
            end else if (rx_data >= MULTI_BYTE_THRESH) begin
              r_state <= ST_VLEN;
            end else begin
              r_vcnt  <= 8'd1;
              r_state <= ST_VALUE;
            end
          end
          ST_VLEN: begin
            r_sum    <= w_sum_nxt;
            r_remain <= w_remain_nxt;
            if (w_remain_nxt == 8'd0) begin
              if (rx_data != 8'd0) r_malformed <= 1'b1;
              else                 r_malformed <= r_malformed;
              r_state <= ST_CHK;
            end else if (rx_data == 8'd0) begin
              r_state <= ST_CODE;
            end else begin
              if (rx_data > w_remain_nxt) r_malformed <= 1'b1;
              else                        r_malformed <= r_malformed;
              r_vcnt  <= rx_data;
              r_state <= ST_VALUE;
            end
          end
          ST_VALUE: begin
            r_sum    <= w_sum_nxt;
            r_remain <= w_remain_nxt;
            r_vcnt   <= r_vcnt - 8'd1;
            if (r_code < MULTI_BYTE_THRESH) begin
              case (r_code)
                CODE_SIGNAL: begin r_sh_sig   <= rx_data; r_has_sig   <= 1'b1; end
                CODE_ATTN:   begin r_sh_attn  <= rx_data; r_has_attn  <= 1'b1; end
                CODE_MED:    begin r_sh_med   <= rx_data; r_has_med   <= 1'b1; end
                CODE_BLINK:  begin r_sh_blink <= rx_data; r_has_blink <= 1'b1; end
                default:     r_has_sig <= r_has_sig;
              endcase
            end else begin
              r_has_sig <= r_has_sig;
            end
            if (w_remain_nxt == 8'd0) begin
              if (r_vcnt != 8'd1) r_malformed <= 1'b1;
              else                r_malformed <= r_malformed;
              r_state <= ST_CHK;
            end else if (r_vcnt == 8'd1) begin
              r_state <= ST_CODE;
            end else begin
              r_state <= ST_VALUE;
            end
          end
          ST_CHK: begin
            if (w_good) begin
              if (r_has_sig)   r_out_data[SIG_LSB +: 8]  <= r_sh_sig;
              else             r_out_data[SIG_LSB +: 8]  <= r_out_data[SIG_LSB +: 8];
              if (r_has_attn)  r_out_data[ATTN_LSB +: 8] <= r_sh_attn;
              else             r_out_data[ATTN_LSB +: 8] <= r_out_data[ATTN_LSB +: 8];
              if (r_has_med)   r_out_data[MED_LSB +: 8]  <= r_sh_med;
              else             r_out_data[MED_LSB +: 8]  <= r_out_data[MED_LSB +: 8];
              if (r_has_blink) r_blink_strength <= r_sh_blink;
              else             r_blink_strength <= r_blink_strength;
              r_blink  <= r_has_blink;
              r_pkt_ok <= 1'b1;
            end else begin
              r_chk_err <= 1'b1;
            end
            r_state <= ST_SYNC1;
          end
          default: r_state <= ST_SYNC1;
        endcase
      end else if (r_state != ST_SYNC1) begin
        if (r_idle == TO_LAST) begin
          r_state     <= ST_SYNC1;
          r_chk_err   <= 1'b1;
          r_idle      <= 32'd0;
          r_has_sig   <= 1'b0;
          r_has_attn  <= 1'b0;
          r_has_med   <= 1'b0;
          r_has_blink <= 1'b0;
        end else begin
          r_idle <= r_idle + 32'd1;
        end
      end else begin
        r_idle <= 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_thinkgear_parser.sv
// Directed self-checking bench for thinkgear_parser with hand-computed packets.
module tb_thinkgear_parser;

  localparam int TO = 32;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [23:0] out_data;
  logic [7:0]  blink_strength;
  logic        blink;
  logic        pkt_ok;
  logic        chk_err;

  int n_checks = 0;
  int n_fail   = 0;

  thinkgear_parser #(.TIMEOUT_CYCLES(TO), .MAX_PLEN(169)) dut (
    .clk            (clk),
    .rst            (rst),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .out_data       (out_data),
    .blink_strength (blink_strength),
    .blink          (blink),
    .pkt_ok         (pkt_ok),
    .chk_err        (chk_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bytes go out back-to-back; returns at the negedge where the commit is visible.
  task automatic send_pkt(input logic [7:0] q[$]);
    foreach (q[i]) begin
      @(negedge clk);
      rx_data  = q[i];
      rx_valid = 1'b1;
    end
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  initial begin
    int errs;
    rst      = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_out",   32'(out_data), 32'h00C80000);
    check_val("rst_bs",    32'(blink_strength), 32'h0);
    check_val("rst_pulse", {29'd0, blink, pkt_ok, chk_err}, 32'h0);
    rst = 1'b1;
    @(negedge clk);

    send_pkt('{8'hAA, 8'hAA, 8'h06, 8'h02, 8'h00, 8'h04, 8'h3C, 8'h05, 8'h28, 8'h90});
    check_val("basic_out", 32'(out_data), 32'h00003C28);
    check_val("basic_ok",  {30'd0, pkt_ok, chk_err}, 32'h2);
    @(negedge clk);
    check_val("basic_ok_1cyc", {30'd0, pkt_ok, chk_err}, 32'h0);

    send_pkt('{8'hAA, 8'hAA, 8'h06, 8'h02, 8'h00, 8'h04, 8'h3C, 8'h05, 8'h28, 8'h91});
    check_val("badck_pulse", {30'd0, pkt_ok, chk_err}, 32'h1);
    check_val("badck_out",   32'(out_data), 32'h00003C28);
    @(negedge clk);
    check_val("badck_1cyc", 32'(chk_err), 32'h0);

    send_pkt('{8'hAA, 8'hAA, 8'h02, 8'h16, 8'h50, 8'h99});
    check_val("blink_bs",    32'(blink_strength), 32'h50);
    check_val("blink_pulse", {29'd0, blink, pkt_ok, chk_err}, 32'h6);
    check_val("blink_out",   32'(out_data), 32'h00003C28);

    send_pkt('{8'hAA, 8'hAA, 8'h04, 8'h80, 8'h02, 8'h12, 8'h34, 8'h37});
    check_val("raw_pulse", {29'd0, blink, pkt_ok, chk_err}, 32'h2);
    check_val("raw_out",   32'(out_data), 32'h00003C28);

    send_pkt('{8'hAA, 8'hAA, 8'hAA, 8'h02, 8'h04, 8'h10, 8'hEB});
    check_val("xsync_out", 32'(out_data), 32'h00001028);
    check_val("xsync_ok",  32'(pkt_ok), 32'h1);

    send_pkt('{8'hAA, 8'hAA, 8'hAB, 8'h04, 8'h20, 8'hDB});
    errs = 0;
    for (int i = 0; i < 4; i++) begin
      if (pkt_ok || chk_err) errs++;
      @(negedge clk);
    end
    check_val("plen_big_quiet", 32'(errs), 32'h0);
    check_val("plen_big_out",   32'(out_data), 32'h00001028);

    // VLEN byte would run past the payload: malformed even with a matching checksum.
    send_pkt('{8'hAA, 8'hAA, 8'h02, 8'h80, 8'h05, 8'h7A});
    check_val("malformed", {30'd0, pkt_ok, chk_err}, 32'h1);

    send_pkt('{8'hAA, 8'hAA, 8'h00, 8'hFF});
    check_val("empty_ok",  {30'd0, pkt_ok, chk_err}, 32'h2);
    check_val("empty_out", 32'(out_data), 32'h00001028);

    send_pkt('{8'hAA, 8'hAA, 8'h04, 8'h02});
    errs = 0;
    for (int i = 0; i < TO + 8; i++) begin
      if (chk_err) errs++;
      @(negedge clk);
    end
    check_val("timeout_cnt", 32'(errs), 32'h1);
    check_val("timeout_out", 32'(out_data), 32'h00001028);

    send_pkt('{8'hAA, 8'hAA, 8'h02, 8'h04, 8'h22, 8'hD9});
    check_val("post_to_ok",  32'(pkt_ok), 32'h1);
    check_val("post_to_out", 32'(out_data), 32'h00002228);

    @(negedge clk); rx_data = 8'hAA; rx_valid = 1'b1;
    @(negedge clk); rx_data = 8'hAA;
    @(negedge clk); rx_data = 8'h04;
    @(negedge clk); rx_valid = 1'b0; rst = 1'b0;
    @(negedge clk);
    check_val("midrst_out", 32'(out_data), 32'h00C80000);
    check_val("midrst_bs",  32'(blink_strength), 32'h0);
    rst = 1'b1;
    @(negedge clk);
    send_pkt('{8'hAA, 8'hAA, 8'h02, 8'h05, 8'h11, 8'hE9});
    check_val("after_rst_out", 32'(out_data), 32'h00C80011);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
